// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default widths,
// the NOP encoding and the stage occupancy states.
package pipe_pkg;

    localparam int unsigned INST_W_DEFAULT   = 32;
    localparam int unsigned DATA_W_DEFAULT   = 64;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h00000020;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } stage_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One instruction+payload entry with load enable; async clear to {NOP_INST, 0}.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        INST_W   = INST_W_DEFAULT,
    parameter int unsigned        DATA_W   = DATA_W_DEFAULT,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [DATA_W-1:0] data_o
);

    logic [INST_W-1:0] inst_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q <= NOP_INST;
            data_q <= '0;
        end else if (ld_i) begin
            inst_q <= inst_i;
            data_q <= data_i;
        end
    end

    assign inst_o = inst_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer
// and flush. Optional stall/flush counters under PIPE_STAGE_STATS_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        INST_W   = INST_W_DEFAULT,
    parameter int unsigned        DATA_W   = DATA_W_DEFAULT,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEFAULT)
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int unsigned        CNT_W    = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    stage_state_e      state_q, state_d;
    logic              in_ready_q;
    logic              accept, emit;
    logic              main_ld, skid_ld;
    logic [INST_W-1:0] main_inst_d, main_inst_q, skid_inst_q;
    logic [DATA_W-1:0] main_data_d, main_data_q, skid_data_q;

    assign accept    = in_valid & in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign emit      = out_valid & out_ready;
    assign in_ready  = in_ready_q;
    assign out_inst  = out_valid ? main_inst_q : NOP_INST;
    assign out_data  = main_data_q;

    always_comb begin
        state_d     = state_q;
        main_ld     = 1'b0;
        skid_ld     = 1'b0;
        main_inst_d = in_inst;
        main_data_d = in_data;
        if (flush) begin
            state_d     = EMPTY;
            main_ld     = 1'b1;
            main_inst_d = NOP_INST;
            main_data_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_ld = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = TWO;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        main_ld     = 1'b1;
                        main_inst_d = skid_inst_q;
                        main_data_d = skid_data_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    pipe_entry_reg #(
        .INST_W   (INST_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_i   (main_ld),
        .inst_i (main_inst_d),
        .data_i (main_data_d),
        .inst_o (main_inst_q),
        .data_o (main_data_q)
    );

    pipe_entry_reg #(
        .INST_W   (INST_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_i   (skid_ld),
        .inst_i (in_inst),
        .data_i (in_data),
        .inst_o (skid_inst_q),
        .data_o (skid_data_q)
    );

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush)                   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
